// File: rtl/freq_cnt_pkg.sv
// rtl/freq_cnt_pkg.sv - shared types and constants for the multi-channel frequency counter
// Purpose: edge-select and FSM state encodings plus the default gate length.
// Ports: none (package).
package freq_cnt_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_RSVD = 2'b11
  } edge_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // 100 ms gate at 48 MHz
  localparam int DEFAULT_WINDOW = 4_800_000;

endpackage

// File: rtl/edge_sel_detect.sv
// rtl/edge_sel_detect.sv - synchronized edge detector with selectable edge type
// Purpose: synchronize one input, keep a one-cycle-delayed copy and emit a
//   pulse while the synchronized value differs from it, filtered by edge_mode.
// Ports: clk, rst_n (async active-low), sig (async input),
//   edge_mode (edge selection), pulse (1 while a selected edge is present).
module edge_sel_detect
  import freq_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  edge_mode_t edge_mode,
  output logic       pulse
);

  logic sync;
  logic prev;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= sync;
    end
  end

  // The reserved encoding falls through to rising-edge detection.
  always_comb begin
    pulse = sync & ~prev;
    case (edge_mode)
      EDGE_FALL: pulse = ~sync & prev;
      EDGE_BOTH: pulse = sync ^ prev;
      default:   pulse = sync & ~prev;
    endcase
  end

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
// Purpose: bring an asynchronous pin into the clk domain.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/multi_freq_counter.sv
// rtl/multi_freq_counter.sv - multi-channel gated edge/frequency counter
// Purpose: counts selected edges on NUM_CH async inputs over a WINDOW_CYCLES
//   gate, single-shot or continuous, and publishes saturating per-channel
//   counts with a one-cycle result_valid strobe.
// Ports: clk, reset_in (async active-low), sig_in (inputs to measure),
//   start/stop/cont/edge_mode (control), busy (window open),
//   result_valid (result strobe), count_out (ch i at [i*CNT_W +: CNT_W]),
//   ovf_out (per-channel saturation during the reported window).
module multi_freq_counter
  import freq_cnt_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 10,
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cont,
  input  logic [1:0]              edge_mode,
  output logic                    busy,
  output logic                    result_valid,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       ovf_out
);

  localparam int               TMR_W    = $clog2(WINDOW_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                         state;
  logic [TMR_W-1:0]               timer;
  logic                           cont_q;
  logic                           stop_pend;
  edge_mode_t                     mode_q;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_next;
  logic [NUM_CH-1:0]              ovf;
  logic [NUM_CH-1:0]              edge_pulse;
  logic [NUM_CH-1:0]              sat_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_sel_detect u_det (
      .clk       (clk),
      .rst_n     (reset_in),
      .sig       (sig_in[i]),
      .edge_mode (mode_q),
      .pulse     (edge_pulse[i])
    );
  end

  // An edge arriving at full scale is dropped and flagged as overflow.
  always_comb begin
    sat_hit  = '0;
    cnt_next = cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      sat_hit[i] = edge_pulse[i] && (cnt[i] == CNT_MAX);
      if (edge_pulse[i] && !sat_hit[i]) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state        <= ST_IDLE;
      timer        <= '0;
      cont_q       <= 1'b0;
      stop_pend    <= 1'b0;
      mode_q       <= EDGE_RISE;
      cnt          <= '0;
      ovf          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      count_out    <= '0;
      ovf_out      <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_COUNT;
            busy      <= 1'b1;
            cont_q    <= cont;
            mode_q    <= edge_mode_t'(edge_mode);
            timer     <= '0;
            cnt       <= '0;
            ovf       <= '0;
            stop_pend <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (timer == TMR_LAST) begin
            // Terminal cycle still counts its own edge; the next window starts
            // immediately with cleared counters.
            count_out    <= cnt_next;
            ovf_out      <= ovf | sat_hit;
            result_valid <= 1'b1;
            timer        <= '0;
            cnt          <= '0;
            ovf          <= '0;
            if (!cont_q || stop_pend || stop) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TMR_W'(1);
            cnt   <= cnt_next;
            ovf   <= ovf | sat_hit;
          end
        end
      endcase
    end
  end

endmodule
